ram_stream_writer: RTL and testbench
====================================

Name: ram_stream_writer

Overview:
- Write-side companion to the parameterized single-port RAM read path (addr in, data out).
- Accepts a valid/ready data stream and writes a programmed number of words into consecutive RAM addresses from a base address, wrapping modulo RAM_DEPTH.
- Sits between a producer (DMA/fill engine) and the RAM write port; reports progress, completion and abort status.

Parameters:
- DATA_WIDTH, 32, width of stream data and RAM write data.
- ADDR_WIDTH, 8, RAM address width.
- RAM_DEPTH, 1 << ADDR_WIDTH, localparam (not overridable), number of RAM words.

Ports:
- clk  input  1  single clock; all logic is on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  one-cycle request to begin a transfer; honoured only in IDLE.
- base_addr  input  ADDR_WIDTH  first write address; sampled on an accepted start.
- length  input  ADDR_WIDTH+1  number of words, 0..RAM_DEPTH; sampled on an accepted start.
- abort  input  1  terminates an active transfer.
- s_valid  input  1  stream data valid.
- s_ready  output  1  stream ready.
- s_data  input  DATA_WIDTH  stream data.
- wr_en  output  1  RAM write enable.
- wr_addr  output  ADDR_WIDTH  RAM write address.
- wr_data  output  DATA_WIDTH  RAM write data.
- busy  output  1  high in WRITE and DONE.
- done  output  1  one-cycle completion pulse.
- aborted  output  1  last transfer ended by abort; held until the next accepted start.
- count  output  ADDR_WIDTH+1  words written in the current or last transfer.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE. s_ready, wr_en, busy, done, aborted = 0; count, wr_addr, wr_data = 0. Reset mid-transfer drops any pending write: no wr_en in the cycle after reset.
- States: IDLE, WRITE, DONE.
- IDLE, start=1 at edge t:
  - Latch base_addr into the address pointer and length into the remaining counter; clear count and aborted.
  - length==0: next state DONE. Otherwise next state WRITE.
- start outside IDLE: ignored; latched values unchanged.
- s_ready = (state==WRITE) && !abort. This is combinational; it is the only combinational output.
- Handshake: a beat is accepted when s_valid && s_ready at an edge.
- For a beat accepted at edge t, in cycle t+1:
  - wr_en=1, wr_data=s_data, wr_addr=pointer value at t.
  - pointer increments by 1, wrapping RAM_DEPTH-1 -> 0.
  - count increments by 1; remaining decrements by 1.
  - This is fixed 1-cycle write latency.
- wr_en is 0 in every cycle not following an accepted beat. wr_addr and wr_data hold their last values when wr_en=0.
- Accepting the beat that makes remaining 0 moves the state to DONE. That final write's wr_en coincides with the DONE cycle.
- abort=1 in WRITE at edge t: no beat accepted at t. Next state DONE, aborted=1; count holds words already written.
- abort in IDLE or DONE: no effect.
- DONE lasts exactly one cycle: done=1, busy=1, then IDLE. done is never high outside DONE.
- length==RAM_DEPTH with base_addr!=0: addresses wrap and every RAM word is written exactly once.
- A length greater than RAM_DEPTH is out of contract. The block must clamp it to RAM_DEPTH.
- Widths: count and remaining are ADDR_WIDTH+1 bits. Pointer arithmetic is ADDR_WIDTH bits, modulo 2^ADDR_WIDTH.
- Throughput: one word per cycle while s_valid is held high. s_valid low stalls without penalty.

Test Plan:
- Reset, then start, base_addr=0x10, length=4, s_valid constantly high, data 0xA0..0xA3:
  - wr_en high for 4 consecutive cycles starting 2 cycles after start, addresses 0x10..0x13.
  - done high in the same cycle as the final write; count=4; busy low the following cycle.
- Wrap: ADDR_WIDTH=8, base_addr=0xFE, length=4 -> wr_addr sequence 0xFE, 0xFF, 0x00, 0x01; no write lost or duplicated.
- Backpressure/gaps: length=3, s_valid pattern 1,0,0,1,0,1:
  - exactly 3 writes, each one cycle after its accepted beat, addresses consecutive.
  - s_ready stays high throughout WRITE.
- Abort: length=8, abort asserted together with s_valid after 3 beats accepted:
  - that beat is not accepted; done pulses next cycle; aborted=1, count=3.
  - A subsequent start clears aborted.
- length=0 start -> done pulses the cycle after start; wr_en never asserts; count=0.
- start pulses during WRITE are ignored.
- rst_n low for one cycle mid-transfer (after 2 of 5 beats):
  - all outputs zero the next cycle; no wr_en follows.
  - A fresh start with length=2 completes normally.

Source files
------------

// File: rtl/ram_stream_writer.sv
// Stream-to-RAM write engine: accepts valid/ready beats and writes a programmed
// number of words to consecutive addresses from a base, wrapping modulo RAM_DEPTH.
module ram_stream_writer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  abort,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH + 1)'(RAM_DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                  state_reg;
  logic [ADDR_WIDTH-1:0]   ptr_reg;
  logic [ADDR_WIDTH:0]     remaining_reg;
  logic [ADDR_WIDTH:0]     count_reg;
  logic                    wr_en_reg;
  logic [ADDR_WIDTH-1:0]   wr_addr_reg;
  logic [DATA_WIDTH-1:0]   wr_data_reg;
  logic                    busy_reg;
  logic                    done_reg;
  logic                    aborted_reg;
  logic                    accept;

  // abort takes priority over a beat offered in the same cycle
  assign s_ready = (state_reg == WRITE) && !abort;
  assign accept  = s_valid && s_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      remaining_reg <= '0;
      count_reg     <= '0;
      wr_en_reg     <= 1'b0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      aborted_reg   <= 1'b0;
    end else begin
      wr_en_reg <= 1'b0;
      done_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            ptr_reg       <= base_addr;
            remaining_reg <= (length > DEPTH_CNT) ? DEPTH_CNT : length;
            count_reg     <= '0;
            aborted_reg   <= 1'b0;
            busy_reg      <= 1'b1;
            if (length == '0) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= WRITE;
            end
          end
        end
        WRITE: begin
          if (abort) begin
            state_reg   <= DONE;
            done_reg    <= 1'b1;
            aborted_reg <= 1'b1;
          end else if (accept) begin
            wr_en_reg     <= 1'b1;
            wr_addr_reg   <= ptr_reg;
            wr_data_reg   <= s_data;
            ptr_reg       <= ptr_reg + ADDR_ONE;
            count_reg     <= count_reg + CNT_ONE;
            remaining_reg <= remaining_reg - CNT_ONE;
            // the final write lands in the same cycle as the done pulse
            if (remaining_reg == CNT_ONE) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign wr_en   = wr_en_reg;
  assign wr_addr = wr_addr_reg;
  assign wr_data = wr_data_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;
  assign aborted = aborted_reg;
  assign count   = count_reg;

endmodule

// File: tb/tb_ram_stream_writer.sv
// Bench for ram_stream_writer: cycle-by-cycle comparison against a transfer-level
// model, plus literal checks on write sequences, timing and status.
module tb_ram_stream_writer;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic          abort = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          done;
  logic          aborted;
  logic [AW:0]   count;

  ram_stream_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .length(length), .abort(abort), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .aborted(aborted), .count(count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 60)
        $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Transfer-level model: an active transfer owns a next address and a words-left
  // tally; the completion cycle follows the last write or an abort.
  bit            m_active = 1'b0;
  bit            m_fin = 1'b0;
  int            m_addr = 0;
  int            m_left = 0;
  bit            e_wr_en = 1'b0;
  bit            e_busy = 1'b0;
  bit            e_done = 1'b0;
  bit            e_aborted = 1'b0;
  int            e_count = 0;
  logic [AW-1:0] e_wr_addr = '0;
  logic [DW-1:0] e_wr_data = '0;

  always @(posedge clk) begin : model
    bit act, fin, we, bz, dn, ab;
    int a, left, cnt;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    act = m_active; fin = m_fin; a = m_addr; left = m_left; cnt = e_count;
    we = 1'b0; dn = 1'b0; bz = e_busy; ab = e_aborted; wa = e_wr_addr; wd = e_wr_data;
    if (!rst_n) begin
      act = 0; fin = 0; a = 0; left = 0; cnt = 0; bz = 0; ab = 0; wa = '0; wd = '0;
    end else if (fin) begin
      fin = 0; bz = 0;
    end else if (act) begin
      if (abort) begin
        act = 0; fin = 1; dn = 1; ab = 1;
      end else if (s_valid) begin
        we = 1; wa = AW'(a); wd = s_data;
        a = (a + 1) % DEPTH;
        cnt = cnt + 1;
        left = left - 1;
        if (left == 0) begin
          act = 0; fin = 1; dn = 1;
        end
      end
    end else if (start) begin
      a = int'(base_addr);
      left = (int'(length) > DEPTH) ? DEPTH : int'(length);
      cnt = 0; ab = 0; bz = 1;
      if (left == 0) begin
        fin = 1; dn = 1;
      end else begin
        act = 1;
      end
    end
    m_active <= act; m_fin <= fin; m_addr <= a; m_left <= left; e_count <= cnt;
    e_wr_en <= we; e_busy <= bz; e_done <= dn; e_aborted <= ab;
    e_wr_addr <= wa; e_wr_data <= wd;
  end

  int wl_addr[$];
  int wl_data[$];
  int wl_cyc[$];
  int dn_cyc[$];

  always @(negedge clk) begin
    if (chk_en) begin
      chk("s_ready", 64'(s_ready), 64'(m_active && !abort));
      chk("wr_en", 64'(wr_en), 64'(e_wr_en));
      chk("wr_addr", 64'(wr_addr), 64'(e_wr_addr));
      chk("wr_data", 64'(wr_data), 64'(e_wr_data));
      chk("busy", 64'(busy), 64'(e_busy));
      chk("done", 64'(done), 64'(e_done));
      chk("aborted", 64'(aborted), 64'(e_aborted));
      chk("count", 64'(count), 64'(e_count));
    end
    if (wr_en === 1'b1) begin
      wl_addr.push_back(int'(wr_addr));
      wl_data.push_back(int'(wr_data));
      wl_cyc.push_back(cyc);
    end
    if (done === 1'b1) dn_cyc.push_back(cyc);
  end

  bit          post_done, post_busy, post_aborted, post_wr_en, post2_busy;
  logic [AW:0] post_count;

  // mode 0: valid always high; 1: valid pattern 1,0,0,1,0,1; 2: random valid/data/start noise
  task automatic xfer(input int base, input int len, input int mode, input int data0,
                      input int abort_after, input int rst_after, output int sc);
    int acc = 0;
    int k = 0;
    int guard = 0;
    bit v, acc_now;
    bit pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    sc = cyc;
    start = 1'b1; base_addr = AW'(base); length = (AW + 1)'(len);
    @(posedge clk); #1;
    start = 1'b0; base_addr = AW'($urandom); length = (AW + 1)'($urandom);
    while (m_active && guard < 3000) begin
      case (mode)
        0: v = 1'b1;
        1: v = pat[k % 6];
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      abort = (abort_after >= 0 && acc == abort_after);
      rst_n = !(rst_after >= 0 && acc == rst_after);
      if (abort || !rst_n) v = 1'b1;
      if (mode == 2 && $urandom_range(0, 7) == 0) begin
        start = 1'b1; base_addr = AW'($urandom); length = (AW + 1)'($urandom);
      end else begin
        start = 1'b0;
      end
      s_valid = v;
      s_data = (mode == 2) ? DW'($urandom) : DW'(data0 + acc);
      @(negedge clk);
      acc_now = s_valid && s_ready;
      @(posedge clk); #1;
      if (acc_now) acc++;
      k++;
      guard++;
    end
    chk("xfer_cycle_budget", 64'(guard < 3000), 64'(1));
    start = 1'b0; s_valid = 1'b0; abort = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    post_done = done; post_busy = busy; post_aborted = aborted;
    post_wr_en = wr_en; post_count = count;
    @(posedge clk); #1;
    @(negedge clk);
    post2_busy = busy;
    @(posedge clk); #1;
  endtask

  initial begin : stim
    int sc, w0, d0;
    int exp_wrap[4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    int gap_ofs[3] = '{2, 5, 7};
    int hits[DEPTH];

    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_wr_en", 64'(wr_en), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_aborted", 64'(aborted), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_s_ready", 64'(s_ready), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // basic: base 0x10, 4 words, data 0xA0..
    w0 = wl_addr.size(); d0 = dn_cyc.size();
    xfer(32'h10, 4, 0, 32'hA0, -1, -1, sc);
    chk("basic_nwrites", 64'(wl_addr.size() - w0), 64'(4));
    for (int i = 0; i < 4 && w0 + i < wl_addr.size(); i++) begin
      chk("basic_addr", 64'(wl_addr[w0 + i]), 64'(32'h10 + i));
      chk("basic_data", 64'(wl_data[w0 + i]), 64'(32'hA0 + i));
      chk("basic_cycle", 64'(wl_cyc[w0 + i] - sc), 64'(2 + i));
    end
    chk("basic_done_cycle", 64'((dn_cyc.size() > d0) ? dn_cyc[d0] - sc : -1), 64'(5));
    chk("basic_done", 64'(post_done), 64'(1));
    chk("basic_last_wr", 64'(post_wr_en), 64'(1));
    chk("basic_count", 64'(post_count), 64'(4));
    chk("basic_busy_after", 64'(post2_busy), 64'(0));

    // address wrap
    w0 = wl_addr.size();
    xfer(32'hFE, 4, 0, 32'h100, -1, -1, sc);
    chk("wrap_nwrites", 64'(wl_addr.size() - w0), 64'(4));
    for (int i = 0; i < 4 && w0 + i < wl_addr.size(); i++)
      chk("wrap_addr", 64'(wl_addr[w0 + i]), 64'(exp_wrap[i]));

    // valid gaps
    w0 = wl_addr.size();
    xfer(32'h40, 3, 1, 32'h200, -1, -1, sc);
    chk("gap_nwrites", 64'(wl_addr.size() - w0), 64'(3));
    for (int i = 0; i < 3 && w0 + i < wl_addr.size(); i++) begin
      chk("gap_addr", 64'(wl_addr[w0 + i]), 64'(32'h40 + i));
      chk("gap_cycle", 64'(wl_cyc[w0 + i] - sc), 64'(gap_ofs[i]));
    end
    chk("gap_count", 64'(post_count), 64'(3));

    // abort after 3 beats
    w0 = wl_addr.size();
    xfer(32'h80, 8, 0, 32'h300, 3, -1, sc);
    chk("abort_nwrites", 64'(wl_addr.size() - w0), 64'(3));
    chk("abort_done", 64'(post_done), 64'(1));
    chk("abort_flag", 64'(post_aborted), 64'(1));
    chk("abort_count", 64'(post_count), 64'(3));
    chk("abort_no_wr", 64'(post_wr_en), 64'(0));

    // zero length also clears the abort flag
    w0 = wl_addr.size(); d0 = dn_cyc.size();
    xfer(32'h05, 0, 0, 0, -1, -1, sc);
    chk("len0_nwrites", 64'(wl_addr.size() - w0), 64'(0));
    chk("len0_done_cycle", 64'((dn_cyc.size() > d0) ? dn_cyc[d0] - sc : -1), 64'(1));
    chk("len0_aborted_cleared", 64'(post_aborted), 64'(0));
    chk("len0_count", 64'(post_count), 64'(0));

    // reset after 2 of 5 beats, then a fresh 2-word transfer
    w0 = wl_addr.size();
    xfer(32'h20, 5, 0, 32'h400, -1, 2, sc);
    chk("rstmid_nwrites", 64'(wl_addr.size() - w0), 64'(2));
    chk("rstmid_wr_en", 64'(post_wr_en), 64'(0));
    chk("rstmid_busy", 64'(post_busy), 64'(0));
    chk("rstmid_done", 64'(post_done), 64'(0));
    chk("rstmid_count", 64'(post_count), 64'(0));
    w0 = wl_addr.size();
    xfer(32'h30, 2, 0, 32'h500, -1, -1, sc);
    chk("after_rst_nwrites", 64'(wl_addr.size() - w0), 64'(2));
    chk("after_rst_done", 64'(post_done), 64'(1));
    chk("after_rst_count", 64'(post_count), 64'(2));

    // random transfers with stray start pulses
    for (int t = 0; t < 12; t++) begin
      int ln = $urandom_range(1, 40);
      w0 = wl_addr.size();
      xfer($urandom_range(0, DEPTH - 1), ln, 2, 0, -1, -1, sc);
      chk("rand_nwrites", 64'(wl_addr.size() - w0), 64'(ln));
      chk("rand_count", 64'(post_count), 64'(ln));
    end

    // full-depth transfer from a nonzero base: each word written once
    w0 = wl_addr.size();
    xfer(32'h37, DEPTH, 2, 0, -1, -1, sc);
    chk("full_nwrites", 64'(wl_addr.size() - w0), 64'(DEPTH));
    foreach (hits[i]) hits[i] = 0;
    for (int i = w0; i < wl_addr.size(); i++) hits[wl_addr[i]]++;
    for (int i = 0; i < DEPTH; i++)
      if (hits[i] != 1) chk("full_coverage", 64'(hits[i]), 64'(1));
    chk("full_first_addr", 64'((wl_addr.size() > w0) ? wl_addr[w0] : -1), 64'(32'h37));

    // out-of-contract length is clamped
    w0 = wl_addr.size();
    xfer(32'h90, 300, 0, 32'h700, -1, -1, sc);
    chk("clamp_nwrites", 64'(wl_addr.size() - w0), 64'(DEPTH));
    chk("clamp_count", 64'(post_count), 64'(DEPTH));

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
